// File: rtl/mult_8x8_seq_sched.sv
// mult_8x8_seq_sched: sequential approximate 8x8 multiplier.
// One exact 4x4 partial-product unit is shared across four quadrant cycles.
// Each quadrant product is truncated by a runtime 2-bit code, shifted into
// place and added into a 16-bit accumulator.
//
// Optional feature macro: MULT_SEQ_EARLY_ZERO_EN
//   When defined, a zero operand finishes the operation straight from Q0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready high only in IDLE)
//   a, b                  8-bit operands
//   cfg_we, cfg_wdata     config register write port, codes {q3,q2,q1,q0}
//   cfg                   current config register contents
//   out_valid/out_ready   result handshake
//   r                     16-bit approximate product
//   busy                  high whenever the FSM is not in IDLE
module mult_8x8_seq_sched #(
  parameter logic [7:0] CFG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_wdata,
  output logic [7:0]  cfg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic        busy
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned RES_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Q0   = 3'd1,
    Q1   = 3'd2,
    Q2   = 3'd3,
    Q3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0]  a_q, b_q, cfg_w;
  logic [RES_W-1:0] acc_q;

  logic             accept;
  logic [NIB_W-1:0] nib_a, nib_b;
  logic [1:0]       code;
  logic [3:0]       shamt;
  logic [OP_W-1:0]  pp, pp_trunc;
  logic [RES_W-1:0] term;

  assign accept = in_valid && (state_q == IDLE);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = Q0;
      Q0: begin
        state_d = Q1;
`ifdef MULT_SEQ_EARLY_ZERO_EN
        if ((a_q == '0) || (b_q == '0)) state_d = DONE;
`endif
      end
      Q1:   state_d = Q2;
      Q2:   state_d = Q3;
      Q3:   state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; status outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Quadrant operand/shift/code select for the shared 4x4 unit
  always_comb begin
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
    code  = cfg_w[1:0];
    shamt = 4'd0;
    case (state_q)
      Q1: begin
        nib_b = b_q[7:4];
        code  = cfg_w[3:2];
        shamt = 4'd4;
      end
      Q2: begin
        nib_a = a_q[7:4];
        code  = cfg_w[5:4];
        shamt = 4'd4;
      end
      Q3: begin
        nib_a = a_q[7:4];
        nib_b = b_q[7:4];
        code  = cfg_w[7:6];
        shamt = 4'd8;
      end
      default: ;
    endcase
  end

  // Exact 4x4 product, then zero `code` LSBs and align
  assign pp       = OP_W'(nib_a) * OP_W'(nib_b);
  assign pp_trunc = pp & (8'hFF << code);
  assign term     = RES_W'(pp_trunc) << shamt;

  // Operand/working-config capture and accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cfg_w <= CFG_RESET;
      acc_q <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      cfg_w <= cfg;
      acc_q <= '0;
    end else if ((state_q == Q0) || (state_q == Q1) ||
                 (state_q == Q2) || (state_q == Q3)) begin
      acc_q <= acc_q + term;
    end
  end

  // Config register, writable in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cfg <= CFG_RESET;
    else if (cfg_we) cfg <= cfg_wdata;
  end

  assign r = acc_q;

endmodule
